// File: rtl/alarm_ring_ctrl.sv
// Alarm ringing session sequencer: beep pattern, stop/snooze, ring timeout,
// and the level-held stop_alarm clear back to the alarm-compare block.
module alarm_ring_ctrl #(
    parameter int SNOOZE_SEC       = 300,
    parameter int RING_TIMEOUT_SEC = 60,
    parameter int MAX_SNOOZE       = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        alarm_in,
    input  logic        alarm_enable,
    input  logic        tick_sec,
    input  logic        tick_beep,
    input  logic        snooze_btn,
    input  logic        stop_btn,
    output logic        stop_alarm,
    output logic        buzzer,
    output logic        ringing,
    output logic        snoozing,
    output logic [3:0]  snooze_count,
    output logic [15:0] snooze_remain,
    output logic        missed
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RING   = 2'd1,
        SNOOZE = 2'd2
    } state_t;

    localparam logic [15:0] SNZ_LEN  = SNOOZE_SEC[15:0];
    localparam logic [15:0] RING_END = 16'(RING_TIMEOUT_SEC - 1);
    localparam logic [3:0]  SNZ_MAX  = MAX_SNOOZE[3:0];

    state_t      r_state, w_state;
    logic        r_alarm_d;
    logic [15:0] r_ring_sec, w_ring_sec;
    logic [3:0]  r_snz_cnt, w_snz_cnt;
    logic [15:0] r_snz_rem, w_snz_rem;
    logic        r_buzzer, w_buzzer;
    logic        r_missed, w_missed;
    logic        r_stop_alarm;
    logic        w_rise;

    assign w_rise = alarm_in & ~r_alarm_d;

    always_comb begin
        w_state    = r_state;
        w_ring_sec = r_ring_sec;
        w_snz_cnt  = r_snz_cnt;
        w_snz_rem  = r_snz_rem;
        w_buzzer   = r_buzzer;
        w_missed   = r_missed;
        unique case (r_state)
            IDLE: begin
                w_buzzer = 1'b0;
                if (w_rise && alarm_enable) begin
                    w_state    = RING;
                    w_snz_cnt  = 4'd0;
                    w_ring_sec = 16'd0;
                    w_snz_rem  = 16'd0;
                    w_buzzer   = 1'b1;
                    w_missed   = 1'b0;
                end
            end
            RING: begin
                if (stop_btn) begin
                    w_state  = IDLE;
                    w_buzzer = 1'b0;
                end else if (snooze_btn && r_snz_cnt < SNZ_MAX) begin
                    w_state   = SNOOZE;
                    w_snz_cnt = r_snz_cnt + 4'd1;
                    w_snz_rem = SNZ_LEN;
                    w_buzzer  = 1'b0;
                end else if (tick_sec && r_ring_sec == RING_END) begin
                    w_state  = IDLE;
                    w_missed = 1'b1;
                    w_buzzer = 1'b0;
                end else begin
                    if (tick_sec && r_ring_sec != 16'hFFFF)
                        w_ring_sec = r_ring_sec + 16'd1;
                    if (tick_beep)
                        w_buzzer = ~r_buzzer;
                end
            end
            SNOOZE: begin
                w_buzzer = 1'b0;
                if (stop_btn) begin
                    w_state = IDLE;
                end else if (tick_sec && r_snz_rem == 16'd1) begin
                    w_state    = RING;
                    w_ring_sec = 16'd0;
                    w_buzzer   = 1'b1;
                    w_snz_rem  = 16'd0;
                end else if (tick_sec && r_snz_rem != 16'd0) begin
                    w_snz_rem = r_snz_rem - 16'd1;
                end
            end
            default: begin
                w_state  = IDLE;
                w_buzzer = 1'b0;
            end
        endcase
        if (stop_btn)
            w_missed = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_alarm_d    <= 1'b0;
            r_ring_sec   <= 16'd0;
            r_snz_cnt    <= 4'd0;
            r_snz_rem    <= 16'd0;
            r_buzzer     <= 1'b0;
            r_missed     <= 1'b0;
            r_stop_alarm <= 1'b0;
        end else begin
            r_state      <= w_state;
            r_alarm_d    <= alarm_in;
            r_ring_sec   <= w_ring_sec;
            r_snz_cnt    <= w_snz_cnt;
            r_snz_rem    <= w_snz_rem;
            r_buzzer     <= w_buzzer;
            r_missed     <= w_missed;
            // Held while alarm_in is high so the clear survives a re-set
            r_stop_alarm <= alarm_in & (w_state != RING);
        end
    end

    assign stop_alarm    = r_stop_alarm;
    assign buzzer        = r_buzzer;
    assign ringing       = (r_state == RING);
    assign snoozing      = (r_state == SNOOZE);
    assign snooze_count  = r_snz_cnt;
    assign snooze_remain = r_snz_rem;
    assign missed        = r_missed;

endmodule
